banked_program_memory: RTL and testbench
========================================

BANKED_PROGRAM_MEMORY -- requirements
Module: banked_program_memory

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of word banks (1..16).
REQ-002 SHALL have parameter BANK_WORDS, default 2048, words per bank (power of 2).
REQ-003 SHALL have parameter INIT_CLEAR, default 1, zero-fill all banks after reset when 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PC  input  [31:2]  instruction word address.
REQ-007 SHALL have port i_req  input  1  instruction fetch request.
REQ-008 SHALL have port instr  output  32  fetched instruction.
REQ-009 SHALL have port i_valid  output  1  instr valid strobe.
REQ-010 SHALL have port address  input  [31:2]  data word address.
REQ-011 SHALL have port d_req  input  1  data access request.
REQ-012 SHALL have port wen  input  1  write when d_req=1.
REQ-013 SHALL have port byte_select_vector  input  4  byte enables; bit n selects data_in[8n+7:8n].
REQ-014 SHALL have port data_in  input  32  write data.
REQ-015 SHALL have port data_out  output  32  read data.
REQ-016 SHALL have port d_valid  output  1  data response strobe.
REQ-017 SHALL have port addr_err  output  1  out-of-range flag, qualified by d_valid/i_valid.
REQ-018 SHALL have port ready  output  1  high when requests are accepted.

Function
REQ-019 Word index w = address[31:2] (or PC[31:2]); bank = w / BANK_WORDS; offset = w mod BANK_WORDS.
REQ-020 w >= NUM_BANKS*BANK_WORDS SHALL be out of range: write suppressed, read data 0, addr_err=1 with the response strobe.
REQ-021 Accepted request (req=1 and ready=1) SHALL produce its valid strobe exactly 1 cycle later, one cycle wide.
REQ-022 Bank select SHALL be registered with the request; output mux uses the registered select, never the current address.
REQ-023 Write SHALL update only enabled bytes of exactly one bank; all other banks untouched.
REQ-024 d_valid SHALL pulse for reads and writes; on writes data_out = pre-write word (read-first).
REQ-025 Same-cycle data write and instruction fetch of the same word: instr SHALL return the old word; next fetch returns new.
REQ-026 Both ports SHALL be usable every cycle (throughput 1 per port per cycle, no stalls in READY).
REQ-027 FSM states: CLEAR, READY. After reset release: CLEAR if INIT_CLEAR=1 else READY.
REQ-028 CLEAR: counter 0..BANK_WORDS-1 writes 0 to that offset in all banks simultaneously, one per cycle; after offset BANK_WORDS-1 -> READY (BANK_WORDS cycles total).
REQ-029 ready=1 only in READY; requests while ready=0 SHALL be ignored (no strobe, no write).
REQ-030 data_out/instr SHALL hold last value when no strobe.

Reset
REQ-031 Reset asserted: i_valid=0, d_valid=0, addr_err=0, ready=0, instr=0, data_out=0, clear counter=0, state=CLEAR (INIT_CLEAR=1) / READY (INIT_CLEAR=0) on release.
REQ-032 Reset during CLEAR SHALL restart the clear from offset 0; memory contents otherwise not reset.
REQ-033 Strobe pending at reset assertion SHALL be dropped.

Structure
REQ-034 Package pm_pkg SHALL hold FSM state enum (CLEAR, READY) and derived width helpers (bank/offset bit widths).
REQ-035 One sub-module pm_bank: true dual-port BANK_WORDS x 32 RAM, byte write enables, read-first, instantiated NUM_BANKS times via generate.
REQ-036 Target 120-400 lines RTL; no latches; block RAM inference in pm_bank.

Verification
REQ-037 INIT_CLEAR=1, release reset, write memory pre-load ignored -> ready rises after exactly 2048 cycles; fetch PC=5 -> instr=0.
REQ-038 Write 0xDEADBEEF at w=2047 and 0x12345678 at w=2048 -> reads return each value, 1-cycle latency, no cross-bank aliasing.
REQ-039 Write 0xFFFFFFFF then byte_select=4'b0010, data_in=0x0000AB00 -> read 0xFFFFABFF.
REQ-040 Same cycle: write w=10 with 0x11 and fetch PC=10 (old 0x0) -> instr=0x0, next fetch 0x11.
REQ-041 Read/write w=4096 (NUM_BANKS=2) -> d_valid=1, addr_err=1, data_out=0, no bank modified.
REQ-042 Assert reset at clear offset 1000 -> ready stays 0, clear restarts, ready after 2048 further cycles.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and width helpers for the banked program memory.
// Sizes are derived from the bank count and the number of words per bank.
package pm_pkg;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } pm_state_e;

    // Address bits needed to pick one word within a bank.
    function automatic int unsigned offset_bits(int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Address bits needed to pick one bank.
    function automatic int unsigned bank_bits(int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/pm_bank.sv
// One bank: true dual-port WORDS x 32 RAM, read-first on both ports.
// Port a serves data access and clear, with byte write enables; port b serves instruction fetch.
module pm_bank
    import pm_pkg::*;
#(
    parameter int unsigned WORDS = 2048,
    localparam int unsigned AW   = offset_bits(WORDS)
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [3:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
            for (int i = 0; i < 4; i++) begin
                if (a_we[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // A write on port a in the same cycle is not yet visible here, so b returns the old word.
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/banked_program_memory.sv
// Banked instruction/data memory: one fetch port and one data port, 1-cycle latency each.
// After reset it can zero-fill every bank, one offset per cycle, before it accepts requests.
module banked_program_memory
    import pm_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned BANK_WORDS = 2048,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] PC,
    input  logic        i_req,
    output logic [31:0] instr,
    output logic        i_valid,
    input  logic [31:2] address,
    input  logic        d_req,
    input  logic        wen,
    input  logic [3:0]  byte_select_vector,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        d_valid,
    output logic        addr_err,
    output logic        ready
);

    localparam int unsigned OFF_W       = offset_bits(BANK_WORDS);
    localparam int unsigned BANK_W      = bank_bits(NUM_BANKS);
    localparam logic [30:0] TOTAL_WORDS = 31'(NUM_BANKS * BANK_WORDS);

    pm_state_e          state_q, state_d;
    logic [OFF_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               clearing;
    logic               d_acc, i_acc, d_in_range, i_in_range;
    logic [BANK_W-1:0]  d_bank, i_bank, d_sel_q, i_sel_q;
    logic               d_valid_q, i_valid_q, d_oor_q, i_oor_q;
    logic [31:0]        data_hold_q, instr_hold_q;
    logic [31:0]        d_rdata [NUM_BANKS];
    logic [31:0]        i_rdata [NUM_BANKS];

    assign clearing   = (state_q == StClear);
    assign ready      = (state_q == StReady);
    assign d_acc      = d_req & ready;
    assign i_acc      = i_req & ready;
    assign d_in_range = {1'b0, address} < TOTAL_WORDS;
    assign i_in_range = {1'b0, PC} < TOTAL_WORDS;
    assign d_bank     = address[2+OFF_W +: BANK_W];
    assign i_bank     = PC[2+OFF_W +: BANK_W];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clearing) begin
            clr_cnt_d = clr_cnt_q + OFF_W'(1);
            if (clr_cnt_q == OFF_W'(BANK_WORDS - 1)) begin
                state_d   = StReady;
                clr_cnt_d = '0;
            end
        end
    end

    // While clearing, port a of every bank writes zero at the shared counter offset.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic d_hit, i_hit;
        assign d_hit = d_acc & d_in_range & (d_bank == BANK_W'(b));
        assign i_hit = i_acc & i_in_range & (i_bank == BANK_W'(b));

        pm_bank #(
            .WORDS(BANK_WORDS)
        ) u_bank (
            .clk    (clk),
            .a_en   (clearing | d_hit),
            .a_we   (clearing ? 4'hF : ((d_hit & wen) ? byte_select_vector : 4'h0)),
            .a_addr (clearing ? clr_cnt_q : address[2 +: OFF_W]),
            .a_wdata(clearing ? 32'h0 : data_in),
            .a_rdata(d_rdata[b]),
            .b_en   (i_hit),
            .b_addr (PC[2 +: OFF_W]),
            .b_rdata(i_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= (INIT_CLEAR != 0) ? StClear : StReady;
            clr_cnt_q    <= '0;
            d_valid_q    <= 1'b0;
            i_valid_q    <= 1'b0;
            d_oor_q      <= 1'b0;
            i_oor_q      <= 1'b0;
            d_sel_q      <= '0;
            i_sel_q      <= '0;
            data_hold_q  <= '0;
            instr_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            d_valid_q    <= d_acc;
            i_valid_q    <= i_acc;
            data_hold_q  <= data_out;
            instr_hold_q <= instr;
            if (d_acc) begin
                d_oor_q <= ~d_in_range;
                d_sel_q <= d_bank;
            end
            if (i_acc) begin
                i_oor_q <= ~i_in_range;
                i_sel_q <= i_bank;
            end
        end
    end

    // Bank read registers can move during clear, so outputs come from hold registers
    // except in the strobe cycle.
    always_comb begin
        data_out = data_hold_q;
        instr    = instr_hold_q;
        if (d_valid_q) begin
            data_out = d_oor_q ? 32'h0 : d_rdata[d_sel_q];
        end
        if (i_valid_q) begin
            instr = i_oor_q ? 32'h0 : i_rdata[i_sel_q];
        end
    end

    assign d_valid  = d_valid_q;
    assign i_valid  = i_valid_q;
    assign addr_err = (d_valid_q & d_oor_q) | (i_valid_q & i_oor_q);

endmodule

// File: tb/tb_banked_program_memory.sv
// Directed bench for banked_program_memory with default parameters (2 banks x 2048 words, clear).
module tb_banked_program_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] PC = '0;
    logic        i_req = 1'b0;
    logic [31:0] instr;
    logic        i_valid;
    logic [31:2] address = '0;
    logic        d_req = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  byte_select_vector = 4'h0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        d_valid;
    logic        addr_err;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    banked_program_memory #(
        .NUM_BANKS (2),
        .BANK_WORDS(2048),
        .INIT_CLEAR(1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .PC                (PC),
        .i_req             (i_req),
        .instr             (instr),
        .i_valid           (i_valid),
        .address           (address),
        .d_req             (d_req),
        .wen               (wen),
        .byte_select_vector(byte_select_vector),
        .data_in           (data_in),
        .data_out          (data_out),
        .d_valid           (d_valid),
        .addr_err          (addr_err),
        .ready             (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic data_op(input logic [29:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] d);
        @(negedge clk);
        address            = a;
        wen                = we;
        byte_select_vector = be;
        data_in            = d;
        d_req              = 1'b1;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        wen   = 1'b0;
    endtask

    task automatic fetch(input logic [29:0] pc);
        @(negedge clk);
        PC    = pc;
        i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    // Counts rising edges until ready; any strobe while waiting is recorded.
    task automatic wait_ready(input string tag, output logic strobe_seen);
        int cnt = 0;
        strobe_seen = 1'b0;
        while (!ready && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!ready) strobe_seen = strobe_seen | d_valid | i_valid;
        end
        chk(tag, 32'(cnt), 32'd2048);
    endtask

    logic seen;

    initial begin
        #1;
        chk1("rst_i_valid", i_valid, 1'b0);
        chk1("rst_d_valid", d_valid, 1'b0);
        chk1("rst_addr_err", addr_err, 1'b0);
        chk1("rst_ready", ready, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_data_out", data_out, 32'h0);

        // Requests held during clear must be ignored.
        address            = 30'd5;
        wen                = 1'b1;
        byte_select_vector = 4'hF;
        data_in            = 32'hFFFF_FFFF;
        d_req              = 1'b1;
        PC                 = 30'd5;
        i_req              = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_ready("clear_cycles", seen);
        d_req = 1'b0;
        i_req = 1'b0;
        wen   = 1'b0;
        chk1("no_strobe_in_clear", seen, 1'b0);
        chk1("ready_high", ready, 1'b1);

        fetch(30'd5);
        chk1("fetch5_valid", i_valid, 1'b1);
        chk("fetch5_instr", instr, 32'h0);
        chk1("fetch5_err", addr_err, 1'b0);
        @(posedge clk);
        #1;
        chk1("i_valid_one_wide", i_valid, 1'b0);

        data_op(30'd2047, 1'b1, 4'hF, 32'hDEAD_BEEF);
        chk1("wr2047_valid", d_valid, 1'b1);
        chk("wr2047_prewrite", data_out, 32'h0);
        data_op(30'd2048, 1'b1, 4'hF, 32'h1234_5678);
        chk("wr2048_prewrite", data_out, 32'h0);
        data_op(30'd2047, 1'b0, 4'h0, 32'h0);
        chk("rd2047", data_out, 32'hDEAD_BEEF);
        data_op(30'd2048, 1'b0, 4'h0, 32'h0);
        chk("rd2048", data_out, 32'h1234_5678);
        chk1("rd2048_err", addr_err, 1'b0);
        data_op(30'd0, 1'b0, 4'h0, 32'h0);
        chk("rd0_no_alias", data_out, 32'h0);
        data_op(30'd4095, 1'b0, 4'h0, 32'h0);
        chk("rd4095_no_alias", data_out, 32'h0);

        data_op(30'd20, 1'b1, 4'hF, 32'hFFFF_FFFF);
        data_op(30'd20, 1'b1, 4'b0010, 32'h0000_AB00);
        chk("byte_prewrite", data_out, 32'hFFFF_FFFF);
        data_op(30'd20, 1'b0, 4'h0, 32'h0);
        chk("byte_merge", data_out, 32'hFFFF_ABFF);

        // Write and fetch of the same word in one cycle.
        @(negedge clk);
        address            = 30'd10;
        wen                = 1'b1;
        byte_select_vector = 4'hF;
        data_in            = 32'h11;
        d_req              = 1'b1;
        PC                 = 30'd10;
        i_req              = 1'b1;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        i_req = 1'b0;
        wen   = 1'b0;
        chk1("same_i_valid", i_valid, 1'b1);
        chk1("same_d_valid", d_valid, 1'b1);
        chk("same_old_instr", instr, 32'h0);
        fetch(30'd10);
        chk("same_new_instr", instr, 32'h11);

        // Back-to-back on both ports.
        @(negedge clk);
        address = 30'd2047;
        d_req   = 1'b1;
        PC      = 30'd2048;
        i_req   = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_d0", data_out, 32'hDEAD_BEEF);
        chk("b2b_i0", instr, 32'h1234_5678);
        address = 30'd2048;
        PC      = 30'd2047;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        i_req = 1'b0;
        chk1("b2b_valid1", d_valid, 1'b1);
        chk("b2b_d1", data_out, 32'h1234_5678);
        chk("b2b_i1", instr, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk1("idle_d_valid", d_valid, 1'b0);
        chk("hold_data_out", data_out, 32'h1234_5678);
        chk("hold_instr", instr, 32'hDEAD_BEEF);

        data_op(30'd4096, 1'b1, 4'hF, 32'hAAAA_5555);
        chk1("oor_wr_valid", d_valid, 1'b1);
        chk1("oor_wr_err", addr_err, 1'b1);
        chk("oor_wr_data", data_out, 32'h0);
        data_op(30'd4096, 1'b0, 4'h0, 32'h0);
        chk1("oor_rd_err", addr_err, 1'b1);
        chk("oor_rd_data", data_out, 32'h0);
        data_op(30'd0, 1'b0, 4'h0, 32'h0);
        chk("oor_bank0_intact", data_out, 32'h0);
        chk1("err_clears", addr_err, 1'b0);
        data_op(30'd2048, 1'b0, 4'h0, 32'h0);
        chk("oor_bank1_intact", data_out, 32'h1234_5678);
        fetch(30'd4096);
        chk1("oor_fetch_err", addr_err, 1'b1);
        chk("oor_fetch_instr", instr, 32'h0);

        // Reset drops a pending strobe, then interrupts a clear part-way.
        data_op(30'd2047, 1'b0, 4'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk1("rst_drops_strobe", d_valid, 1'b0);
        chk("rst_data_out_zero", data_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk1("mid_clear_not_ready", ready, 1'b0);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        wait_ready("restart_clear_cycles", seen);
        fetch(30'd2047);
        chk("cleared_2047", instr, 32'h0);
        data_op(30'd2048, 1'b0, 4'h0, 32'h0);
        chk("cleared_2048", data_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
